tpu_input_feeder: RTL and testbench

Streams input vectors from the TPU input memory into the left edge of the systolic array, one row per cycle, with the diagonal skew the array requires: lane k is delayed k cycles relative to lane 0. It sits between the input memory, which is written through the Avalon `INPUT_OFFSET` window, and the array's data inputs. It is kicked off by the control register's multiply enable.

---
 rtl/tpu_input_feeder.sv | 167 ++++++++++++++++
 tb/tb_tpu_input_feeder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_input_feeder.sv
// tpu_input_feeder: streams rows from the TPU input memory into the left edge of the systolic
// array. Rows go out one per cycle with a diagonal skew: lane k lags lane 0 by k cycles.
//
// Ports:
//   clk_i          rising-edge clock
//   reset_i        asynchronous, active-high reset
//   start_i        one-cycle stream request (honoured only when idle and not in the done cycle)
//   base_addr_i    first memory row, captured with start_i
//   num_rows_i     number of rows to stream, captured with start_i (0 gives an immediate done)
//   mem_rd_en_o    read strobe to the input memory
//   mem_rd_addr_o  read address (base + row, wraps modulo 2^ADDR_W)
//   mem_rd_data_i  memory data, valid one cycle after mem_rd_en_o; lane k = [k*WIDTH +: WIDTH]
//   sa_data_o      skewed lane data to the array (registered)
//   sa_valid_o     per-lane valid (registered)
//   busy_o         high from the cycle after an accepted start until done
//   done_o         one-cycle completion pulse
//
// Build option: define TPU_FEEDER_ZERO_PAD_EN to drive zeros on invalid lanes. Without it an
// invalid lane holds its last valid value and only sa_valid_o qualifies the data.
// ARRAY must be at least 2.
module tpu_input_feeder #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ARRAY  = 4,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic [ADDR_W-1:0]       base_addr_i,
  input  logic [ADDR_W-1:0]       num_rows_i,
  output logic                    mem_rd_en_o,
  output logic [ADDR_W-1:0]       mem_rd_addr_o,
  input  logic [ARRAY*WIDTH-1:0]  mem_rd_data_i,
  output logic [ARRAY*WIDTH-1:0]  sa_data_o,
  output logic [ARRAY-1:0]        sa_valid_o,
  output logic                    busy_o,
  output logic                    done_o
);

  // The drain counter must reach ARRAY, so it needs room for ARRAY+1 distinct values.
  localparam int unsigned CntW = $clog2(ARRAY + 2);
  localparam logic [CntW-1:0]   DrainLast = CntW'(ARRAY);
  localparam logic [ADDR_W-1:0] AddrOne   = ADDR_W'(1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] num_q;
  logic [ADDR_W-1:0] row_q;
  logic [CntW-1:0]   drain_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              busy_q;
  logic              done_q;
  logic              vld_in_q;

  // Control FSM with registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      base_q    <= '0;
      num_q     <= '0;
      row_q     <= '0;
      drain_q   <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A start that coincides with the done pulse belongs to the finished stream.
          if (start_i && !done_q) begin
            if (num_rows_i != '0) begin
              state_q   <= StRead;
              base_q    <= base_addr_i;
              num_q     <= num_rows_i;
              row_q     <= '0;
              rd_en_q   <= 1'b1;
              rd_addr_q <= base_addr_i;
              busy_q    <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StRead: begin
          if (row_q == num_q - AddrOne) begin
            state_q <= StDrain;
            rd_en_q <= 1'b0;
            drain_q <= '0;
          end else begin
            row_q     <= row_q + AddrOne;
            rd_addr_q <= base_q + row_q + AddrOne;
          end
        end
        StDrain: begin
          // ARRAY+1 cycles: one for the memory latency plus the deepest lane's pipeline.
          if (drain_q == DrainLast) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Memory data is valid one cycle after the read strobe.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      vld_in_q <= 1'b0;
    end else begin
      vld_in_q <= rd_en_q;
    end
  end

  // Skew pipeline: lane k has k delay stages plus the output register, i.e. k+1 registers.
  // Index 0 is fed from memory; index k drives the array.
  for (genvar k = 0; k < ARRAY; k++) begin : g_lane
    logic [WIDTH-1:0] stg_q [k+1];
    logic [k:0]       sv_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        for (int j = 0; j <= k; j++) begin
          stg_q[j] <= '0;
        end
        sv_q <= '0;
      end else begin
        sv_q[0] <= vld_in_q;
`ifdef TPU_FEEDER_ZERO_PAD_EN
        stg_q[0] <= vld_in_q ? mem_rd_data_i[k*WIDTH +: WIDTH] : '0;
`else
        if (vld_in_q) begin
          stg_q[0] <= mem_rd_data_i[k*WIDTH +: WIDTH];
        end
`endif
        for (int j = 1; j <= k; j++) begin
          sv_q[j] <= sv_q[j-1];
`ifdef TPU_FEEDER_ZERO_PAD_EN
          stg_q[j] <= sv_q[j-1] ? stg_q[j-1] : '0;
`else
          // Stages hold when their input is invalid, so the output keeps its last valid value.
          if (sv_q[j-1]) begin
            stg_q[j] <= stg_q[j-1];
          end
`endif
        end
      end
    end

    assign sa_data_o[k*WIDTH +: WIDTH] = stg_q[k];
    assign sa_valid_o[k]               = sv_q[k];
  end

  assign mem_rd_en_o   = rd_en_q;
  assign mem_rd_addr_o = rd_addr_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_tpu_input_feeder.sv
// Self-checking bench for tpu_input_feeder: a table of stream configurations with hand-computed
// completion data, plus directed sequences for start-while-busy, mid-stream reset and padding.
module tb_tpu_input_feeder;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned ARRAY  = 4;
  localparam int unsigned ADDR_W = 8;
  localparam int          MAXC   = 64;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [ADDR_W-1:0]      base_addr;
  logic [ADDR_W-1:0]      num_rows;
  logic                   mem_rd_en;
  logic [ADDR_W-1:0]      mem_rd_addr;
  logic [ARRAY*WIDTH-1:0] mem_rd_data;
  logic [ARRAY*WIDTH-1:0] sa_data;
  logic [ARRAY-1:0]       sa_valid;
  logic                   busy;
  logic                   done;

  always #5 clk = ~clk;

  tpu_input_feeder #(
    .WIDTH (WIDTH),
    .ARRAY (ARRAY),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .num_rows_i   (num_rows),
    .mem_rd_en_o  (mem_rd_en),
    .mem_rd_addr_o(mem_rd_addr),
    .mem_rd_data_i(mem_rd_data),
    .sa_data_o    (sa_data),
    .sa_valid_o   (sa_valid),
    .busy_o       (busy),
    .done_o       (done)
  );

  // Input memory model: address a holds four copies of byte (a - 0x0F), so address 0x10 + i
  // holds {4{i+1}}. Registered read, one cycle latency.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  // Per-cycle logs; cycle 0 is the cycle in which start is presented.
  logic        l_rd   [MAXC];
  logic [7:0]  l_addr [MAXC];
  logic [31:0] l_sa   [MAXC];
  logic [3:0]  l_sv   [MAXC];
  logic        l_busy [MAXC];
  logic        l_done [MAXC];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] elem(input logic [7:0] a, input int k);
    logic [31:0] row;
    row = mem[a];
    return row[k*8 +: 8];
  endfunction

  // Present start in cycle 0, then log len cycles. Extra starts at cycles s1..s3 and a
  // one-cycle reset pulse at cycle rc (negative = none).
  task automatic run(input logic [7:0] b, input logic [7:0] n, input int s1, input int s2,
                     input int s3, input int rc, input int len);
    @(posedge clk); #1;
    base_addr = b;
    num_rows  = n;
    start     = 1'b1;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      l_rd[c]   = mem_rd_en;
      l_addr[c] = mem_rd_addr;
      l_sa[c]   = sa_data;
      l_sv[c]   = sa_valid;
      l_busy[c] = busy;
      l_done[c] = done;
      @(posedge clk); #1;
      start = (c + 1 == s1) || (c + 1 == s2) || (c + 1 == s3);
      reset = (c + 1 == rc);
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  // Check logged cycles 0..win against the expected stream shape.
  task automatic check_stream(input string nm, input logic [7:0] b, input int n,
                              input int done_exp, input int win);
    int          rd_err, bz_err, dn_cnt, dn_at, r;
    int          ln_err [4];
    logic        exp_rd, exp_bz, ev;
    logic [31:0] w;
    rd_err = 0; bz_err = 0; dn_cnt = 0; dn_at = -1;
    for (int k = 0; k < 4; k++) ln_err[k] = 0;
    for (int c = 0; c <= win; c++) begin
      exp_rd = (c >= 1) && (c <= n);
      if (l_rd[c] !== exp_rd || (exp_rd && l_addr[c] !== 8'(int'(b) + c - 1))) rd_err++;
      exp_bz = (n != 0) && (c >= 1) && (c <= n + ARRAY + 1);
      if (l_busy[c] !== exp_bz) bz_err++;
      if (l_done[c] === 1'b1) begin
        dn_cnt++;
        dn_at = c;
      end
      w = l_sa[c];
      for (int k = 0; k < 4; k++) begin
        r  = c - k - 3;
        ev = (r >= 0) && (r < n);
        if (l_sv[c][k] !== ev || (ev && w[k*8 +: 8] !== elem(8'(int'(b) + r), k))) ln_err[k]++;
      end
    end
    chk({nm, ".rd_seq"}, rd_err, 0);
    chk({nm, ".busy"}, bz_err, 0);
    chk({nm, ".done_count"}, dn_cnt, 1);
    chk({nm, ".done_cycle"}, dn_at, done_exp);
    for (int k = 0; k < 4; k++) chk($sformatf("%s.lane%0d", nm, k), ln_err[k], 0);
  endtask

  typedef struct {
    logic [7:0] base;
    logic [7:0] num;
    int         done_cyc;
    int         busy_cnt;
    logic [7:0] last_addr;
  } vec_t;

  initial begin
    vec_t vecs [5];
    int   bc, seen, bad;

    vecs[0] = '{base: 8'h10, num: 8'd3,  done_cyc: 9,  busy_cnt: 8,  last_addr: 8'h12};
    vecs[1] = '{base: 8'hFE, num: 8'd4,  done_cyc: 10, busy_cnt: 9,  last_addr: 8'h01};
    vecs[2] = '{base: 8'h00, num: 8'd0,  done_cyc: 1,  busy_cnt: 0,  last_addr: 8'h00};
    vecs[3] = '{base: 8'h20, num: 8'd1,  done_cyc: 7,  busy_cnt: 6,  last_addr: 8'h20};
    vecs[4] = '{base: 8'h80, num: 8'd10, done_cyc: 16, busy_cnt: 15, last_addr: 8'h89};

    for (int a = 0; a < 256; a++) mem[a] = {4{8'(a - 15)}};
    mem_rd_data = '0;
    reset       = 1'b1;
    start       = 1'b0;
    base_addr   = '0;
    num_rows    = '0;

    // Reset values.
    #12;
    chk("reset_values", {mem_rd_en, mem_rd_addr, sa_data, sa_valid, busy, done}, '0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Table-driven streams.
    for (int i = 0; i < 5; i++) begin
      run(vecs[i].base, vecs[i].num, -1, -1, -1, -1, vecs[i].done_cyc + 3);
      check_stream($sformatf("vec%0d", i), vecs[i].base, int'(vecs[i].num), vecs[i].done_cyc,
                   vecs[i].done_cyc + 2);
      bc = 0;
      for (int c = 0; c <= vecs[i].done_cyc + 2; c++) if (l_busy[c] === 1'b1) bc++;
      chk($sformatf("vec%0d.busy_cycles", i), bc, vecs[i].busy_cnt);
      if (vecs[i].num != 0)
        chk($sformatf("vec%0d.last_addr", i), l_addr[vecs[i].num], vecs[i].last_addr);
    end

    // Basic stream, spot values and padding behaviour.
    run(8'h10, 8'd3, -1, -1, -1, -1, 12);
    chk("basic.lane0_c3", {l_sv[3][0], l_sa[3][7:0]}, {1'b1, 8'h01});
    chk("basic.lane0_c4", {l_sv[4][0], l_sa[4][7:0]}, {1'b1, 8'h02});
    chk("basic.lane0_c5", {l_sv[5][0], l_sa[5][7:0]}, {1'b1, 8'h03});
    chk("basic.lane3_c6", {l_sv[6][3], l_sa[6][31:24]}, {1'b1, 8'h01});
    chk("basic.lane3_c8", {l_sv[8][3], l_sa[8][31:24]}, {1'b1, 8'h03});
    chk("basic.done_c9", l_done[9], 1'b1);
`ifdef TPU_FEEDER_ZERO_PAD_EN
    chk("pad.lane3_c5", l_sa[5][31:24], 8'h00);
    chk("pad.lane3_c9", l_sa[9][31:24], 8'h00);
    chk("pad.lane0_c6", l_sa[6][7:0], 8'h00);
`else
    chk("hold.lane3_c9", l_sa[9][31:24], 8'h03);
    chk("hold.lane3_c11", l_sa[11][31:24], 8'h03);
    chk("hold.lane0_c6", l_sa[6][7:0], 8'h03);
`endif

    // Start while busy (cycles 2 and 9 ignored), start in cycle 10 accepted.
    run(8'h10, 8'd3, 2, 9, 10, -1, 13);
    check_stream("busy_start", 8'h10, 3, 9, 10);
    chk("restart.rd_c11", {l_rd[11], l_addr[11], l_busy[11]}, {1'b1, 8'h10, 1'b1});
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    chk("restart.done_seen", seen, 1);
    @(posedge clk); #1;

    // Reset in cycle 4 of an 8-row stream.
    run(8'h10, 8'd8, -1, -1, -1, 4, 30);
    chk("midrst.outputs_c4",
        {l_rd[4], l_addr[4], l_sa[4], l_sv[4], l_busy[4], l_done[4]}, '0);
    bad = 0;
    for (int c = 5; c < 30; c++) begin
      if (l_done[c] !== 1'b0 || l_rd[c] !== 1'b0 || l_sv[c] !== 4'h0 || l_busy[c] !== 1'b0)
        bad++;
    end
    chk("midrst.quiet_after", bad, 0);
    run(8'h10, 8'd3, -1, -1, -1, -1, 12);
    check_stream("midrst.fresh", 8'h10, 3, 9, 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
